axil_reg_cmd_master: RTL and testbench

Hardware command sequencer sitting directly upstream of `axil_reg_ctrl`: accepts single-word memory read/write commands on a valid/ready stream and executes the indirect-register protocol over an AXI4-Lite master port into the `axil_reg_ctrl` slave. Each command is carried out as data-register load, address-register kick, busy-bit polling and data readback. It replaces software/bench sequencing, so on-chip logic can reach the RAM behind `axil_reg_ctrl` without a CPU.

---
 rtl/axil_reg_cmd_pkg.sv | 27 ++
 rtl/axil_lite_xfer.sv | 106 ++++++++++
 rtl/axil_reg_cmd_master.sv | 205 ++++++++++++++++++++
 tb/tb_axil_reg_cmd_master.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_reg_cmd_pkg.sv
// rtl/axil_reg_cmd_pkg.sv - register map, error codes and FSM states for axil_reg_cmd_master
package axil_reg_cmd_pkg;

  localparam logic [31:0] OFF_RD_ADDR = 32'h0;
  localparam logic [31:0] OFF_RD_DATA = 32'h4;
  localparam logic [31:0] OFF_WR_ADDR = 32'h8;
  localparam logic [31:0] OFF_WR_DATA = 32'hC;
  localparam int          BUSY_BIT    = 31;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_SLAVE   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_WR_DATA = 3'd1;
  localparam state_t ST_WR_KICK = 3'd2;
  localparam state_t ST_RD_KICK = 3'd3;
  localparam state_t ST_POLL    = 3'd4;
  localparam state_t ST_RD_DATA = 3'd5;
  localparam state_t ST_RESP    = 3'd6;

  function automatic logic [31:0] kick_word(input logic [15:0] addr);
    return {1'b1, 15'h0, addr};
  endfunction

endpackage

// File: rtl/axil_lite_xfer.sv
// rtl/axil_lite_xfer.sv - single AXI4-Lite read or write transaction engine
module axil_lite_xfer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_write,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_strb,
  output logic        o_done,
  output logic [1:0]  o_resp,
  output logic [31:0] o_rdata,
  output logic [31:0] o_awaddr,
  output logic        o_awvalid,
  input  logic        i_awready,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  output logic        o_wvalid,
  input  logic        i_wready,
  input  logic [1:0]  i_bresp,
  input  logic        i_bvalid,
  output logic        o_bready,
  output logic [31:0] o_araddr,
  output logic        o_arvalid,
  input  logic        i_arready,
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_rresp,
  input  logic        i_rvalid,
  output logic        o_rready
);

  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_strb;
  logic [1:0]  r_resp;
  logic        r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready, r_wr_busy, r_done;
  logic        w_aw_clear, w_w_clear;

  // True when each half of the write has been accepted, either earlier or on this edge.
  assign w_aw_clear = !r_awvalid || i_awready;
  assign w_w_clear  = !r_wvalid  || i_wready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_strb    <= '0;
      r_rdata   <= '0;
      r_resp    <= 2'b00;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_wr_busy <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_awvalid && i_awready) r_awvalid <= 1'b0;
      if (r_wvalid && i_wready)   r_wvalid  <= 1'b0;
      if (r_wr_busy && !r_bready && w_aw_clear && w_w_clear) r_bready <= 1'b1;
      if (r_bready && i_bvalid) begin
        r_bready  <= 1'b0;
        r_wr_busy <= 1'b0;
        r_done    <= 1'b1;
        r_resp    <= i_bresp;
        r_rdata   <= '0;
      end
      if (r_arvalid && i_arready) begin
        r_arvalid <= 1'b0;
        r_rready  <= 1'b1;
      end
      if (r_rready && i_rvalid) begin
        r_rready <= 1'b0;
        r_done   <= 1'b1;
        r_resp   <= i_rresp;
        r_rdata  <= i_rdata;
      end
      if (i_start) begin
        r_addr <= i_addr;
        if (i_write) begin
          r_wdata   <= i_wdata;
          r_strb    <= i_strb;
          r_awvalid <= 1'b1;
          r_wvalid  <= 1'b1;
          r_wr_busy <= 1'b1;
        end else begin
          r_arvalid <= 1'b1;
        end
      end
    end
  end

  assign o_done    = r_done;
  assign o_resp    = r_resp;
  assign o_rdata   = r_rdata;
  assign o_awaddr  = r_addr;
  assign o_awvalid = r_awvalid;
  assign o_wdata   = r_wdata;
  assign o_wstrb   = r_strb;
  assign o_wvalid  = r_wvalid;
  assign o_bready  = r_bready;
  assign o_araddr  = r_addr;
  assign o_arvalid = r_arvalid;
  assign o_rready  = r_rready;

endmodule

// File: rtl/axil_reg_cmd_master.sv
// rtl/axil_reg_cmd_master.sv - command sequencer driving the axil_reg_ctrl indirect-register protocol
module axil_reg_cmd_master
  import axil_reg_cmd_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h44A0_0000,
  parameter int          POLL_LIMIT = 1024
) (
  input  logic        axil_aclk,
  input  logic        axil_aresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [15:0] cmd_addr,
  input  logic [31:0] cmd_data,
  input  logic [3:0]  cmd_strb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_err,
  output logic [31:0] m_axil_awaddr,
  output logic [2:0]  m_axil_awprot,
  output logic        m_axil_awvalid,
  input  logic        m_axil_awready,
  output logic [31:0] m_axil_wdata,
  output logic [3:0]  m_axil_wstrb,
  output logic        m_axil_wvalid,
  input  logic        m_axil_wready,
  input  logic [1:0]  m_axil_bresp,
  input  logic        m_axil_bvalid,
  output logic        m_axil_bready,
  output logic [31:0] m_axil_araddr,
  output logic [2:0]  m_axil_arprot,
  output logic        m_axil_arvalid,
  input  logic        m_axil_arready,
  input  logic [31:0] m_axil_rdata,
  input  logic [1:0]  m_axil_rresp,
  input  logic        m_axil_rvalid,
  output logic        m_axil_rready
);

  localparam int          PW          = $clog2(POLL_LIMIT + 1);
  localparam logic [PW-1:0] C_POLL_LAST = PW'(POLL_LIMIT - 1);

  state_t          r_state, w_next;
  logic            r_write;
  logic [15:0]     r_addr;
  logic [PW-1:0]   r_poll_cnt;
  logic            r_rsp_valid;
  logic [31:0]     r_rsp_data;
  logic [1:0]      r_rsp_err;

  logic            w_start, w_xwrite, w_done, w_ok;
  logic [31:0]     w_xaddr, w_xwdata, w_rdata, w_rsp_data;
  logic [3:0]      w_xstrb;
  logic [1:0]      w_resp, w_rsp_err;
  logic            w_poll_clr, w_poll_inc, w_rsp_load;

  assign w_ok = (w_resp == ERR_OK);

  always_comb begin
    w_next     = r_state;
    w_start    = 1'b0;
    w_xwrite   = 1'b0;
    w_xaddr    = '0;
    w_xwdata   = '0;
    w_xstrb    = '0;
    w_poll_clr = 1'b0;
    w_poll_inc = 1'b0;
    w_rsp_load = 1'b0;
    w_rsp_err  = ERR_OK;
    w_rsp_data = '0;
    case (r_state)
      ST_IDLE: if (cmd_valid) begin
        w_start  = 1'b1;
        w_xwrite = 1'b1;
        if (cmd_write) begin
          w_next   = ST_WR_DATA;
          w_xaddr  = BASE_ADDR + OFF_WR_DATA;
          w_xwdata = cmd_data;
          w_xstrb  = cmd_strb;
        end else begin
          w_next   = ST_RD_KICK;
          w_xaddr  = BASE_ADDR + OFF_RD_ADDR;
          w_xwdata = kick_word(cmd_addr);
          w_xstrb  = 4'hF;
        end
      end
      ST_WR_DATA: if (w_done) begin
        if (!w_ok) begin
          w_next = ST_RESP; w_rsp_load = 1'b1; w_rsp_err = ERR_SLAVE;
        end else begin
          w_next   = ST_WR_KICK;
          w_start  = 1'b1;
          w_xwrite = 1'b1;
          w_xaddr  = BASE_ADDR + OFF_WR_ADDR;
          w_xwdata = kick_word(r_addr);
          w_xstrb  = 4'hF;
        end
      end
      ST_WR_KICK, ST_RD_KICK: if (w_done) begin
        if (!w_ok) begin
          w_next = ST_RESP; w_rsp_load = 1'b1; w_rsp_err = ERR_SLAVE;
        end else begin
          w_next     = ST_POLL;
          w_start    = 1'b1;
          w_xaddr    = BASE_ADDR + (r_write ? OFF_WR_ADDR : OFF_RD_ADDR);
          w_poll_clr = 1'b1;
        end
      end
      // Each completed busy read either re-issues the same poll or trips the timeout.
      ST_POLL: if (w_done) begin
        if (!w_ok) begin
          w_next = ST_RESP; w_rsp_load = 1'b1; w_rsp_err = ERR_SLAVE;
        end else if (!w_rdata[BUSY_BIT]) begin
          if (r_write) begin
            w_next = ST_RESP; w_rsp_load = 1'b1;
          end else begin
            w_next  = ST_RD_DATA;
            w_start = 1'b1;
            w_xaddr = BASE_ADDR + OFF_RD_DATA;
          end
        end else if (r_poll_cnt == C_POLL_LAST) begin
          w_next = ST_RESP; w_rsp_load = 1'b1; w_rsp_err = ERR_TIMEOUT;
        end else begin
          w_start    = 1'b1;
          w_xaddr    = BASE_ADDR + (r_write ? OFF_WR_ADDR : OFF_RD_ADDR);
          w_poll_inc = 1'b1;
        end
      end
      ST_RD_DATA: if (w_done) begin
        w_next     = ST_RESP;
        w_rsp_load = 1'b1;
        w_rsp_err  = w_ok ? ERR_OK : ERR_SLAVE;
        w_rsp_data = w_ok ? w_rdata : 32'h0;
      end
      ST_RESP: if (rsp_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
    if (!axil_aresetn) begin
      r_state     <= ST_IDLE;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_poll_cnt  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= ERR_OK;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && cmd_valid) begin
        r_write <= cmd_write;
        r_addr  <= cmd_addr;
      end
      if (w_poll_clr)      r_poll_cnt <= '0;
      else if (w_poll_inc) r_poll_cnt <= r_poll_cnt + 1'b1;
      if (w_rsp_load) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= w_rsp_data;
        r_rsp_err   <= w_rsp_err;
      end else if (r_state == ST_RESP && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  axil_lite_xfer u_xfer (
    .clk       (axil_aclk),
    .rst_n     (axil_aresetn),
    .i_start   (w_start),
    .i_write   (w_xwrite),
    .i_addr    (w_xaddr),
    .i_wdata   (w_xwdata),
    .i_strb    (w_xstrb),
    .o_done    (w_done),
    .o_resp    (w_resp),
    .o_rdata   (w_rdata),
    .o_awaddr  (m_axil_awaddr),
    .o_awvalid (m_axil_awvalid),
    .i_awready (m_axil_awready),
    .o_wdata   (m_axil_wdata),
    .o_wstrb   (m_axil_wstrb),
    .o_wvalid  (m_axil_wvalid),
    .i_wready  (m_axil_wready),
    .i_bresp   (m_axil_bresp),
    .i_bvalid  (m_axil_bvalid),
    .o_bready  (m_axil_bready),
    .o_araddr  (m_axil_araddr),
    .o_arvalid (m_axil_arvalid),
    .i_arready (m_axil_arready),
    .i_rdata   (m_axil_rdata),
    .i_rresp   (m_axil_rresp),
    .i_rvalid  (m_axil_rvalid),
    .o_rready  (m_axil_rready)
  );

  assign cmd_ready     = (r_state == ST_IDLE);
  assign rsp_valid     = r_rsp_valid;
  assign rsp_data      = r_rsp_data;
  assign rsp_err       = r_rsp_err;
  assign m_axil_awprot = 3'h0;
  assign m_axil_arprot = 3'h0;

endmodule

// File: tb/tb_axil_reg_cmd_master.sv
// tb/tb_axil_reg_cmd_master.sv - self-checking bench with an axil_reg_ctrl slave model and response scoreboard
module tb_axil_reg_cmd_master;

  localparam logic [31:0] BASE = 32'h44A0_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [15:0] cmd_addr = 0;
  logic [31:0] cmd_data = 0;
  logic [3:0]  cmd_strb = 0;
  logic        rsp_valid, rsp_ready = 0;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_err;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  axil_reg_cmd_master #(.BASE_ADDR(BASE), .POLL_LIMIT(4)) dut (
    .axil_aclk(clk), .axil_aresetn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
    .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
    .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
    .m_axil_araddr(araddr), .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
    .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(rready)
  );

  int n_checks = 0;
  int n_fail = 0;

  typedef struct { logic [31:0] data; logic [1:0] err; } exp_t;
  exp_t exp_q[$];

  // Slave model of axil_reg_ctrl with delay, error and busy knobs.
  logic [31:0] ram [0:16383];
  logic [31:0] wl_addr[$], wl_data[$];
  logic [3:0]  wl_strb[$];
  int          poll_reads = 0;
  int          busy_polls = 1, busy_left = 0, aw_delay = 0, aw_wait = 0;
  bit          busy_stuck = 0, inj_b = 0;
  logic [31:0] inj_off = 0;
  logic        aw_got, w_got;
  logic [31:0] aw_l, wd_l, s_wd, s_rd, s_wa, s_wdv, s_off;
  logic [3:0]  ws_l, s_ws, s_wsv;
  logic        s_aok, s_wok;

  assign awready = awvalid && !aw_got && !bvalid && (aw_wait >= aw_delay);
  assign wready  = wvalid && !w_got && !bvalid;
  assign arready = arvalid && !rvalid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_got <= 0; w_got <= 0; bvalid <= 0; rvalid <= 0; aw_wait <= 0; busy_left <= 0;
      bresp <= 0; rresp <= 0; rdata <= 0; s_wd <= 0; s_ws <= 0; s_rd <= 0;
      aw_l <= 0; wd_l <= 0; ws_l <= 0;
    end else begin
      if (awvalid && awready) aw_wait <= 0;
      else if (awvalid && !aw_got) aw_wait <= aw_wait + 1;
      s_aok = aw_got || (awvalid && awready);
      s_wok = w_got || (wvalid && wready);
      s_wa  = aw_got ? aw_l : awaddr;
      s_wdv = w_got ? wd_l : wdata;
      s_wsv = w_got ? ws_l : wstrb;
      if (!bvalid && s_aok && s_wok) begin
        s_off = s_wa - BASE;
        wl_addr.push_back(s_wa); wl_data.push_back(s_wdv); wl_strb.push_back(s_wsv);
        if (inj_b && s_off == inj_off) bresp <= 2'b10;
        else begin
          bresp <= 2'b00;
          if (s_off == 32'hC) begin s_wd <= s_wdv; s_ws <= s_wsv; end
          else if (s_off == 32'h8) begin
            for (int i = 0; i < 4; i++)
              if (s_ws[i]) ram[s_wdv[15:2]][8*i +: 8] <= s_wd[8*i +: 8];
            busy_left <= busy_polls;
          end else if (s_off == 32'h0) begin
            s_rd <= ram[s_wdv[15:2]];
            busy_left <= busy_polls;
          end
        end
        bvalid <= 1; aw_got <= 0; w_got <= 0;
      end else begin
        if (awvalid && awready) begin aw_got <= 1; aw_l <= awaddr; end
        if (wvalid && wready) begin w_got <= 1; wd_l <= wdata; ws_l <= wstrb; end
      end
      if (bvalid && bready) bvalid <= 0;
      if (arvalid && arready) begin
        rvalid <= 1; rresp <= 2'b00;
        if (araddr == BASE || araddr == BASE + 32'h8) begin
          poll_reads <= poll_reads + 1;
          rdata <= {(busy_stuck || busy_left > 0), 31'h0};
          if (busy_left > 0) busy_left <= busy_left - 1;
        end else if (araddr == BASE + 32'h4) rdata <= s_rd;
        else rdata <= 32'h0;
      end
      if (rvalid && rready) rvalid <= 0;
    end
  end

  // Protocol monitor: valids hold and payloads stay stable until handshake.
  int aw_hi = 0, w_hi = 0, b_early = 0, proto_err = 0;
  logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
  logic [31:0] p_awa, p_wd, p_ara;
  logic [3:0]  p_ws;
  always @(negedge clk) begin
    if (!rst_n) begin
      p_awv = 0; p_wv = 0; p_arv = 0; p_awr = 0; p_wr = 0; p_arr = 0;
    end else begin
      if (awvalid) aw_hi++;
      if (wvalid) w_hi++;
      if (bready && (awvalid || wvalid)) b_early++;
      if (p_awv && !p_awr && (!awvalid || awaddr !== p_awa)) proto_err++;
      if (p_wv && !p_wr && (!wvalid || wdata !== p_wd || wstrb !== p_ws)) proto_err++;
      if (p_arv && !p_arr && (!arvalid || araddr !== p_ara)) proto_err++;
      p_awv = awvalid; p_awr = awready; p_awa = awaddr;
      p_wv = wvalid; p_wr = wready; p_wd = wdata; p_ws = wstrb;
      p_arv = arvalid; p_arr = arready; p_ara = araddr;
    end
  end

  task automatic send_cmd(input logic w, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    bit acc = 0;
    @(negedge clk);
    cmd_write = w; cmd_addr = a; cmd_data = d; cmd_strb = s; cmd_valid = 1;
    for (int i = 0; i < 100; i++) begin
      if (cmd_ready) begin acc = 1; break; end
      @(negedge clk);
    end
    if (acc) @(negedge clk);
    else begin
      n_checks++; n_fail++;
      $display("FAIL cmd_accept: cmd_ready never seen within 100 cycles");
    end
    cmd_valid = 0; cmd_write = ~w; cmd_addr = 16'hFFFF; cmd_data = 32'hDEADBEEF; cmd_strb = 4'h0;
  endtask

  task automatic wait_rsp(output logic [31:0] d, output logic [1:0] e, output int lat);
    bit got = 0;
    d = 'x; e = 'x;
    rsp_ready = 1; lat = 0;
    for (int i = 0; i < 300; i++) begin
      lat++;
      if (rsp_valid) begin d = rsp_data; e = rsp_err; got = 1; break; end
      @(negedge clk);
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL rsp_timeout: rsp_valid not seen within 300 cycles");
    end
    @(negedge clk);
    rsp_ready = 0;
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [1:0] e);
    exp_t x; x.data = d; x.err = e; exp_q.push_back(x);
  endtask

  task automatic test_reset;
    n_checks++;
    if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid} !== 6'b0) begin
      n_fail++; $display("FAIL reset_valids: got %b required 000000", {awvalid, wvalid, arvalid, bready, rready, rsp_valid});
    end
    n_checks++;
    if (cmd_ready !== 1'b1 || rsp_err !== 2'b00 || rsp_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_rsp: cmd_ready=%b err=%b data=%h required 1/00/0", cmd_ready, rsp_err, rsp_data);
    end
    n_checks++;
    if (awaddr !== 0 || wdata !== 0 || wstrb !== 0 || araddr !== 0 || awprot !== 0 || arprot !== 0) begin
      n_fail++; $display("FAIL reset_payload: awaddr=%h wdata=%h wstrb=%h araddr=%h required 0", awaddr, wdata, wstrb, araddr);
    end
    @(negedge clk); rst_n = 1; @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b required 1", cmd_ready); end
  endtask

  task automatic test_write_read;
    logic [31:0] d; logic [1:0] e; int lat, p0; exp_t x;
    busy_polls = 1; wl_addr.delete(); wl_data.delete(); wl_strb.delete(); p0 = poll_reads;
    push_exp(32'h0, 2'b00);
    send_cmd(1, 16'h0200, 32'h11223344, 4'hF);
    wait_rsp(d, e, lat);
    x = exp_q.pop_front();
    n_checks++;
    if (d !== x.data || e !== x.err) begin n_fail++; $display("FAIL wr_rsp: data=%h err=%b required %h/%b", d, e, x.data, x.err); end
    n_checks++;
    if (wl_addr.size() != 2) begin n_fail++; $display("FAIL wr_count: %0d writes required 2", wl_addr.size()); end
    else begin
      n_checks++;
      if (wl_addr[0] !== 32'h44A0000C || wl_data[0] !== 32'h11223344 || wl_strb[0] !== 4'hF) begin
        n_fail++; $display("FAIL wr_data_reg: %h=%h/%h required 44a0000c=11223344/f", wl_addr[0], wl_data[0], wl_strb[0]);
      end
      n_checks++;
      if (wl_addr[1] !== 32'h44A00008 || wl_data[1] !== 32'h80000200 || wl_strb[1] !== 4'hF) begin
        n_fail++; $display("FAIL wr_kick: %h=%h/%h required 44a00008=80000200/f", wl_addr[1], wl_data[1], wl_strb[1]);
      end
    end
    n_checks++;
    if (poll_reads - p0 != 2) begin n_fail++; $display("FAIL wr_polls: %0d required 2", poll_reads - p0); end
    wl_addr.delete(); wl_data.delete(); wl_strb.delete();
    push_exp(32'h11223344, 2'b00);
    send_cmd(0, 16'h0200, 32'h0, 4'h0);
    wait_rsp(d, e, lat);
    x = exp_q.pop_front();
    n_checks++;
    if (d !== x.data || e !== x.err) begin n_fail++; $display("FAIL rd_rsp: data=%h err=%b required %h/%b", d, e, x.data, x.err); end
    n_checks++;
    if (wl_addr.size() != 1 || wl_addr[0] !== 32'h44A00000 || wl_data[0] !== 32'h80000200) begin
      n_fail++; $display("FAIL rd_kick: %0d writes, first %h required one write 44a00000=80000200", wl_addr.size(), wl_addr.size() > 0 ? wl_data[0] : 32'h0);
    end
  endtask

  task automatic test_latency;
    logic [31:0] d; logic [1:0] e; int lat; exp_t x;
    busy_polls = 0;
    push_exp(32'h0, 2'b00);
    send_cmd(1, 16'h0204, 32'hA5A5A5A5, 4'hF);
    wait_rsp(d, e, lat);
    x = exp_q.pop_front();
    n_checks++;
    if (lat != 10 || d !== x.data || e !== x.err) begin
      n_fail++; $display("FAIL wr_latency: %0d cycles data=%h err=%b required 10 cycles %h/%b", lat, d, e, x.data, x.err);
    end
    busy_polls = 1;
  endtask

  task automatic test_strobe;
    logic [31:0] d; logic [1:0] e; int lat; exp_t x;
    push_exp(32'h0, 2'b00);
    send_cmd(1, 16'h0300, 32'h55667788, 4'h3);
    wait_rsp(d, e, lat);
    x = exp_q.pop_front();
    push_exp(32'h00007788, 2'b00);
    send_cmd(0, 16'h0300, 32'h0, 4'h0);
    wait_rsp(d, e, lat);
    x = exp_q.pop_front();
    n_checks++;
    if (d !== x.data || e !== x.err) begin n_fail++; $display("FAIL strobe_read: data=%h err=%b required %h/%b", d, e, x.data, x.err); end
  endtask

  task automatic test_aw_delay;
    logic [31:0] d; logic [1:0] e; int lat, a0, w0, b0; exp_t x;
    aw_delay = 4; a0 = aw_hi; w0 = w_hi; b0 = b_early;
    push_exp(32'h0, 2'b00);
    send_cmd(1, 16'h0308, 32'hCAFEF00D, 4'hF);
    wait_rsp(d, e, lat);
    x = exp_q.pop_front();
    n_checks++;
    if (aw_hi - a0 != 10 || w_hi - w0 != 2 || b_early != b0) begin
      n_fail++; $display("FAIL aw_delay_timing: aw=%0d w=%0d early_bready=%0d required 10/2/0", aw_hi - a0, w_hi - w0, b_early - b0);
    end
    aw_delay = 0;
    push_exp(32'hCAFEF00D, 2'b00);
    send_cmd(0, 16'h0308, 32'h0, 4'h0);
    wait_rsp(d, e, lat);
    x = exp_q.pop_front();
    n_checks++;
    if (d !== x.data || e !== x.err) begin n_fail++; $display("FAIL aw_delay_read: data=%h err=%b required %h/%b", d, e, x.data, x.err); end
  endtask

  task automatic test_bresp_err;
    logic [31:0] d; logic [1:0] e; int lat; exp_t x;
    inj_b = 1; inj_off = 32'hC; wl_addr.delete(); wl_data.delete(); wl_strb.delete();
    push_exp(32'h0, 2'b01);
    send_cmd(1, 16'h030C, 32'h12345678, 4'hF);
    wait_rsp(d, e, lat);
    x = exp_q.pop_front();
    inj_b = 0;
    n_checks++;
    if (d !== x.data || e !== x.err) begin n_fail++; $display("FAIL bresp_rsp: data=%h err=%b required %h/%b", d, e, x.data, x.err); end
    n_checks++;
    if (wl_addr.size() != 1) begin n_fail++; $display("FAIL bresp_no_kick: %0d writes required 1", wl_addr.size()); end
  endtask

  task automatic test_timeout;
    logic [31:0] d; logic [1:0] e; int lat, p0; exp_t x;
    busy_stuck = 1; p0 = poll_reads;
    push_exp(32'h0, 2'b10);
    send_cmd(0, 16'h0200, 32'h0, 4'h0);
    wait_rsp(d, e, lat);
    x = exp_q.pop_front();
    busy_stuck = 0;
    n_checks++;
    if (d !== x.data || e !== x.err) begin n_fail++; $display("FAIL timeout_rsp: data=%h err=%b required %h/%b", d, e, x.data, x.err); end
    n_checks++;
    if (poll_reads - p0 != 4) begin n_fail++; $display("FAIL timeout_polls: %0d required 4", poll_reads - p0); end
  endtask

  task automatic test_rsp_stall;
    logic [31:0] d; logic [1:0] e; int bad = 0; bit got = 0; exp_t x;
    push_exp(32'h0, 2'b00);
    send_cmd(1, 16'h0310, 32'h0BADF00D, 4'hF);
    rsp_ready = 0;
    for (int i = 0; i < 100; i++) begin
      if (rsp_valid) begin got = 1; break; end
      @(negedge clk);
    end
    d = rsp_data; e = rsp_err;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== d || rsp_err !== e || cmd_ready || awvalid || wvalid || arvalid || bready || rready) bad++;
    end
    x = exp_q.pop_front();
    n_checks++;
    if (!got || bad != 0 || d !== x.data || e !== x.err) begin
      n_fail++; $display("FAIL rsp_stall: seen=%0d unstable_cycles=%0d data=%h err=%b required 1/0/%h/%b", got, bad, d, e, x.data, x.err);
    end
    rsp_ready = 1; @(negedge clk); rsp_ready = 0;
    n_checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rsp_release: cmd_ready=%b rsp_valid=%b required 1/0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] shadow [int];
    logic [31:0] d, dat, m; logic [1:0] e; logic [15:0] a; logic [3:0] s; int lat; bit w; exp_t x;
    for (int k = 0; k < 10; k++) begin
      busy_polls = $urandom_range(0, 3);
      w = (k < 2) ? 1'b1 : 1'($urandom_range(0, 1));
      a = 16'h0400 + 16'(4 * $urandom_range(0, 3));
      dat = $urandom; s = 4'($urandom_range(1, 15));
      if (w) begin
        m = shadow.exists(int'(a)) ? shadow[int'(a)] : 32'h0;
        for (int i = 0; i < 4; i++) if (s[i]) m[8*i +: 8] = dat[8*i +: 8];
        shadow[int'(a)] = m;
        push_exp(32'h0, 2'b00);
      end else begin
        push_exp(shadow.exists(int'(a)) ? shadow[int'(a)] : 32'h0, 2'b00);
      end
      n_checks++;
      if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b required 1", k, cmd_ready); end
      send_cmd(w, a, dat, s);
      wait_rsp(d, e, lat);
      x = exp_q.pop_front();
      n_checks++;
      if (d !== x.data || e !== x.err) begin
        n_fail++; $display("FAIL b2b_rsp[%0d]: write=%0d addr=%h data=%h err=%b required %h/%b", k, w, a, d, e, x.data, x.err);
      end
    end
    busy_polls = 1;
  endtask

  task automatic test_reset_mid_poll;
    logic [31:0] d; logic [1:0] e; int lat; exp_t x;
    busy_stuck = 1;
    send_cmd(0, 16'h0200, 32'h0, 4'h0);
    repeat (6) @(negedge clk);
    #2 rst_n = 0;
    #1;
    n_checks++;
    if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid} !== 6'b0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_async: valids=%b cmd_ready=%b required 000000/1", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, cmd_ready);
    end
    busy_stuck = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mid_ready: got %b required 1", cmd_ready); end
    push_exp(32'h0, 2'b00);
    send_cmd(1, 16'h0320, 32'h600DCAFE, 4'hF);
    wait_rsp(d, e, lat);
    x = exp_q.pop_front();
    push_exp(32'h600DCAFE, 2'b00);
    send_cmd(0, 16'h0320, 32'h0, 4'h0);
    wait_rsp(d, e, lat);
    x = exp_q.pop_front();
    n_checks++;
    if (d !== x.data || e !== x.err) begin n_fail++; $display("FAIL reset_recover: data=%h err=%b required %h/%b", d, e, x.data, x.err); end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) ram[i] = 32'h0;
    repeat (3) @(negedge clk);
    test_reset;
    test_write_read;
    test_latency;
    test_strobe;
    test_aw_delay;
    test_bresp_err;
    test_timeout;
    test_rsp_stall;
    test_back_to_back;
    test_reset_mid_poll;
    n_checks++;
    if (proto_err != 0) begin n_fail++; $display("FAIL axi_protocol: %0d violations required 0", proto_err); end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d left required 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
